// File: rtl/object_mask_encoder_if.sv
// Command/mask bundle between the game-object sequencers (master) and
// the object mask encoder (slave).
interface object_mask_encoder_if #(
    parameter int XW = 160,
    parameter int YW = 120,
    parameter int SW = 4
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_clear;
    logic [7:0]    cmd_x;
    logic [6:0]    cmd_y;
    logic [SW-1:0] cmd_w;
    logic [SW-1:0] cmd_h;
    logic [XW-1:0] mask_x;
    logic [YW-1:0] mask_y;
    logic          mask_valid;
    logic [7:0]    obj_count;

    modport master (
        output cmd_valid, cmd_clear, cmd_x, cmd_y, cmd_w, cmd_h,
        input  cmd_ready, mask_x, mask_y, mask_valid, obj_count
    );

    modport slave (
        input  cmd_valid, cmd_clear, cmd_x, cmd_y, cmd_w, cmd_h,
        output cmd_ready, mask_x, mask_y, mask_valid, obj_count
    );
endinterface

// File: rtl/object_mask_encoder.sv
// Accumulates per-object column/row spans into X/Y masks, one position
// per cycle, for the collision checker.
module object_mask_encoder #(
    parameter int XW = 160,
    parameter int YW = 120,
    parameter int SW = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    object_mask_encoder_if.slave  bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FILL = 1'b1;

    localparam int XI = $clog2(XW);
    localparam int YI = $clog2(YW);
    localparam logic [8:0] X_LIM = 9'(XW);
    localparam logic [8:0] Y_LIM = 9'(YW);

    logic [0:0]    state;
    logic [7:0]    x_q;
    logic [6:0]    y_q;
    logic [SW-1:0] w_q;
    logic [SW-1:0] h_q;
    logic [SW-1:0] k_q;
    logic [SW-1:0] kmax_q;
    logic [XW-1:0] mask_x_q;
    logic [YW-1:0] mask_y_q;
    logic [7:0]    count_q;
    logic [8:0]    pos_x;
    logic [8:0]    pos_y;
    logic          accept;

    assign accept = bus.cmd_valid && (state == IDLE);

    // 9-bit sums so positions past the screen edge are seen and dropped.
    assign pos_x = {1'b0, x_q} + 9'(k_q);
    assign pos_y = {2'b00, y_q} + 9'(k_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            w_q      <= '0;
            h_q      <= '0;
            k_q      <= '0;
            kmax_q   <= '0;
            mask_x_q <= '0;
            mask_y_q <= '0;
            count_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (bus.cmd_clear) begin
                            mask_x_q <= '0;
                            mask_y_q <= '0;
                            count_q  <= '0;
                        end else begin
                            x_q    <= bus.cmd_x;
                            y_q    <= bus.cmd_y;
                            w_q    <= bus.cmd_w;
                            h_q    <= bus.cmd_h;
                            k_q    <= '0;
                            kmax_q <= (bus.cmd_w > bus.cmd_h) ? bus.cmd_w : bus.cmd_h;
                            state  <= FILL;
                        end
                    end
                end
                FILL: begin
                    if ((k_q <= w_q) && (pos_x < X_LIM))
                        mask_x_q[pos_x[XI-1:0]] <= 1'b1;
                    if ((k_q <= h_q) && (pos_y < Y_LIM))
                        mask_y_q[pos_y[YI-1:0]] <= 1'b1;
                    if (k_q == kmax_q) begin
                        state <= IDLE;
                        if (count_q != 8'hFF)
                            count_q <= count_q + 8'd1;
                    end else begin
                        k_q <= k_q + SW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready  = (state == IDLE);
    assign bus.mask_valid = (state == IDLE);
    assign bus.mask_x     = mask_x_q;
    assign bus.mask_y     = mask_y_q;
    assign bus.obj_count  = count_q;
endmodule

// File: tb/tb_object_mask_encoder.sv
// Self-checking bench for object_mask_encoder against a span-list
// reference model of the screen masks.
module tb_object_mask_encoder;
    localparam int XW = 160;
    localparam int YW = 120;
    localparam int SW = 4;

    logic clock;
    logic reset;

    object_mask_encoder_if #(.XW(XW), .YW(YW), .SW(SW)) bus ();

    object_mask_encoder #(.XW(XW), .YW(YW), .SW(SW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks;
    int n_fail;

    logic [XW-1:0] m_x;
    logic [YW-1:0] m_y;
    int            m_cnt;

    // Reference: mark every covered column/row that lies on screen.
    task automatic model_apply(input logic clr, input int x, input int y,
                               input int w, input int h);
        if (clr) begin
            m_x = '0;
            m_y = '0;
            m_cnt = 0;
        end else begin
            for (int i = 0; i <= w; i++)
                if (x + i < XW) m_x[x + i] = 1'b1;
            for (int j = 0; j <= h; j++)
                if (y + j < YW) m_y[y + j] = 1'b1;
            m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
        end
    endtask

    task automatic model_reset();
        m_x = '0;
        m_y = '0;
        m_cnt = 0;
    endtask

    // Issues one command from IDLE and counts the busy cycles that follow.
    task automatic run_cmd(input logic clr, input int x, input int y,
                           input int w, input int h, output int busy);
        bus.cmd_valid = 1'b1;
        bus.cmd_clear = clr;
        bus.cmd_x = 8'(x);
        bus.cmd_y = 7'(y);
        bus.cmd_w = SW'(w);
        bus.cmd_h = SW'(h);
        @(posedge clock);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_clear = 1'b0;
        busy = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clock);
            if (bus.cmd_ready === 1'b1) return;
            busy++;
        end
        busy = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        n_checks++;
        if (bus.mask_x !== '0 || bus.mask_y !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_masks: got x=%h y=%h, expected zero", bus.mask_x, bus.mask_y);
        end
        n_checks++;
        if (bus.obj_count !== 8'd0 || bus.cmd_ready !== 1'b1 || bus.mask_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_status: got count=%0d ready=%b valid=%b, expected 0/1/1",
                     bus.obj_count, bus.cmd_ready, bus.mask_valid);
        end
    endtask

    task automatic test_single_load();
        int busy;
        run_cmd(1'b0, 10, 20, 3, 1, busy);
        model_apply(1'b0, 10, 20, 3, 1);
        n_checks++;
        if (busy != 4) begin
            n_fail++;
            $display("[TB] FAIL single_busy: got %0d cycles, expected 4", busy);
        end
        n_checks++;
        if (bus.mask_x !== m_x || bus.mask_y !== m_y || bus.obj_count !== 8'(m_cnt)) begin
            n_fail++;
            $display("[TB] FAIL single_masks: got x=%h y=%h cnt=%0d, expected x=%h y=%h cnt=%0d",
                     bus.mask_x, bus.mask_y, bus.obj_count, m_x, m_y, m_cnt);
        end
        n_checks++;
        if (bus.mask_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL single_valid: got %b, expected 1", bus.mask_valid);
        end
    endtask

    task automatic test_edge_clip();
        int busy;
        run_cmd(1'b1, 0, 0, 0, 0, busy);
        model_apply(1'b1, 0, 0, 0, 0);
        run_cmd(1'b0, 158, 118, 3, 3, busy);
        model_apply(1'b0, 158, 118, 3, 3);
        n_checks++;
        if (busy != 4) begin
            n_fail++;
            $display("[TB] FAIL clip_busy: got %0d cycles, expected 4", busy);
        end
        n_checks++;
        if (bus.mask_x !== m_x || bus.mask_y !== m_y || bus.obj_count !== 8'(m_cnt)) begin
            n_fail++;
            $display("[TB] FAIL clip_masks: got x=%h y=%h cnt=%0d, expected x=%h y=%h cnt=%0d",
                     bus.mask_x, bus.mask_y, bus.obj_count, m_x, m_y, m_cnt);
        end
        run_cmd(1'b0, 200, 10, 0, 0, busy);
        model_apply(1'b0, 200, 10, 0, 0);
        n_checks++;
        if (bus.mask_x !== m_x || bus.mask_y !== m_y || bus.obj_count !== 8'(m_cnt) || busy != 1) begin
            n_fail++;
            $display("[TB] FAIL offscreen: got x=%h y=%h cnt=%0d busy=%0d, expected x=%h y=%h cnt=%0d busy=1",
                     bus.mask_x, bus.mask_y, bus.obj_count, busy, m_x, m_y, m_cnt);
        end
    endtask

    task automatic test_accumulate_clear();
        int busy;
        run_cmd(1'b1, 0, 0, 0, 0, busy);
        model_apply(1'b1, 0, 0, 0, 0);
        run_cmd(1'b0, 5, 5, 0, 0, busy);
        model_apply(1'b0, 5, 5, 0, 0);
        run_cmd(1'b0, 50, 60, 1, 2, busy);
        model_apply(1'b0, 50, 60, 1, 2);
        n_checks++;
        if (bus.mask_x !== m_x || bus.mask_y !== m_y || bus.obj_count !== 8'd2) begin
            n_fail++;
            $display("[TB] FAIL accumulate: got x=%h y=%h cnt=%0d, expected x=%h y=%h cnt=2",
                     bus.mask_x, bus.mask_y, bus.obj_count, m_x, m_y);
        end
        // Two clears on consecutive edges; the block must stay ready throughout.
        bus.cmd_valid = 1'b1;
        bus.cmd_clear = 1'b1;
        @(posedge clock);
        #1;
        n_checks++;
        if (bus.cmd_ready !== 1'b1 || bus.mask_x !== '0 || bus.mask_y !== '0 || bus.obj_count !== 8'd0) begin
            n_fail++;
            $display("[TB] FAIL clear: got ready=%b x=%h y=%h cnt=%0d, expected ready=1 all zero",
                     bus.cmd_ready, bus.mask_x, bus.mask_y, bus.obj_count);
        end
        @(posedge clock);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_clear = 1'b0;
        model_apply(1'b1, 0, 0, 0, 0);
        @(negedge clock);
        n_checks++;
        if (bus.cmd_ready !== 1'b1 || bus.mask_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL clear_twice: got ready=%b valid=%b, expected 1/1",
                     bus.cmd_ready, bus.mask_valid);
        end
    endtask

    task automatic test_mid_fill_reset();
        int busy;
        bus.cmd_valid = 1'b1;
        bus.cmd_clear = 1'b0;
        bus.cmd_x = 8'd0;
        bus.cmd_y = 7'd0;
        bus.cmd_w = SW'(15);
        bus.cmd_h = SW'(15);
        @(posedge clock);
        #1;
        bus.cmd_valid = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        n_checks++;
        if (bus.mask_x !== '0 || bus.mask_y !== '0 || bus.obj_count !== 8'd0 || bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL midfill_reset: got x=%h y=%h cnt=%0d ready=%b, expected zero masks ready=1",
                     bus.mask_x, bus.mask_y, bus.obj_count, bus.cmd_ready);
        end
        run_cmd(1'b0, 7, 8, 1, 1, busy);
        model_apply(1'b0, 7, 8, 1, 1);
        n_checks++;
        if (bus.mask_x !== m_x || bus.mask_y !== m_y || bus.obj_count !== 8'(m_cnt) || busy != 2) begin
            n_fail++;
            $display("[TB] FAIL after_reset_load: got x=%h y=%h cnt=%0d busy=%0d, expected x=%h y=%h cnt=%0d busy=2",
                     bus.mask_x, bus.mask_y, bus.obj_count, busy, m_x, m_y, m_cnt);
        end
    endtask

    task automatic test_handshake_holdoff();
        int busy;
        int busy_a;
        run_cmd(1'b1, 0, 0, 0, 0, busy);
        model_apply(1'b1, 0, 0, 0, 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_clear = 1'b0;
        bus.cmd_x = 8'd30;
        bus.cmd_y = 7'd40;
        bus.cmd_w = SW'(5);
        bus.cmd_h = SW'(2);
        @(posedge clock);
        model_apply(1'b0, 30, 40, 5, 2);
        busy_a = -1;
        // Scramble fields (including clear) while the block is busy.
        for (int i = 0; i < 40; i++) begin
            #1;
            bus.cmd_clear = 1'($urandom);
            bus.cmd_x = 8'($urandom);
            bus.cmd_y = 7'($urandom);
            bus.cmd_w = SW'($urandom);
            bus.cmd_h = SW'($urandom);
            @(negedge clock);
            if (bus.cmd_ready === 1'b1) begin
                busy_a = i;
                break;
            end
            @(posedge clock);
        end
        bus.cmd_clear = 1'b0;
        bus.cmd_x = 8'd100;
        bus.cmd_y = 7'd90;
        bus.cmd_w = SW'(2);
        bus.cmd_h = SW'(4);
        n_checks++;
        if (busy_a != 6) begin
            n_fail++;
            $display("[TB] FAIL holdoff_busy: got %0d cycles, expected 6", busy_a);
        end
        run_cmd(1'b0, 100, 90, 2, 4, busy);
        model_apply(1'b0, 100, 90, 2, 4);
        n_checks++;
        if (bus.mask_x !== m_x || bus.mask_y !== m_y || bus.obj_count !== 8'(m_cnt) || busy != 5) begin
            n_fail++;
            $display("[TB] FAIL holdoff_masks: got x=%h y=%h cnt=%0d busy=%0d, expected x=%h y=%h cnt=%0d busy=5",
                     bus.mask_x, bus.mask_y, bus.obj_count, busy, m_x, m_y, m_cnt);
        end
    endtask

    task automatic test_random_loads();
        int busy;
        int x, y, w, h;
        logic clr;
        for (int n = 0; n < 40; n++) begin
            clr = ($urandom_range(0, 5) == 0);
            x = $urandom_range(0, 255);
            y = $urandom_range(0, 127);
            w = $urandom_range(0, 15);
            h = $urandom_range(0, 15);
            run_cmd(clr, x, y, w, h, busy);
            model_apply(clr, x, y, w, h);
            n_checks++;
            if (bus.mask_x !== m_x || bus.mask_y !== m_y || bus.obj_count !== 8'(m_cnt)) begin
                n_fail++;
                $display("[TB] FAIL random_masks[%0d]: got x=%h y=%h cnt=%0d, expected x=%h y=%h cnt=%0d",
                         n, bus.mask_x, bus.mask_y, bus.obj_count, m_x, m_y, m_cnt);
            end
            n_checks++;
            if (busy != (clr ? 0 : ((w > h ? w : h) + 1))) begin
                n_fail++;
                $display("[TB] FAIL random_busy[%0d]: got %0d, expected %0d",
                         n, busy, clr ? 0 : ((w > h ? w : h) + 1));
            end
        end
    endtask

    task automatic test_saturation();
        int busy;
        run_cmd(1'b1, 0, 0, 0, 0, busy);
        model_apply(1'b1, 0, 0, 0, 0);
        for (int n = 0; n < 258; n++) begin
            run_cmd(1'b0, 220, 125, 0, 0, busy);
            model_apply(1'b0, 220, 125, 0, 0);
        end
        n_checks++;
        if (bus.obj_count !== 8'(m_cnt) || bus.mask_x !== '0 || bus.mask_y !== '0) begin
            n_fail++;
            $display("[TB] FAIL saturation: got cnt=%0d x=%h y=%h, expected cnt=%0d zero masks",
                     bus.obj_count, bus.mask_x, bus.mask_y, m_cnt);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_clear = 1'b0;
        bus.cmd_x = '0;
        bus.cmd_y = '0;
        bus.cmd_w = '0;
        bus.cmd_h = '0;
        model_reset();
        test_reset();
        test_single_load();
        test_edge_clip();
        test_accumulate_clear();
        test_mid_fill_reset();
        test_handshake_holdoff();
        test_random_loads();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
